// File: rtl/osr_pull_ctrl_if.sv
// Bundle between the instruction decoder / TX FIFO / OSR and the OSR pull controller.
// master drives requests and FIFO/OSR status; slave is the controller producing the strobes.
interface osr_pull_ctrl_if;
  logic        penable;
  logic        restart;
  logic        out_req;
  logic [4:0]  out_count;
  logic        pull_req;
  logic        pull_block;
  logic        pull_ifempty;
  logic        autopull;
  logic [4:0]  pull_thresh;
  logic [31:0] x_in;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic [5:0]  osr_count;
  logic        fifo_pop;
  logic        osr_set;
  logic [31:0] osr_din;
  logic        osr_do_shift;
  logic [4:0]  osr_shift;
  logic        stall;
  logic [15:0] stall_cycles;

  modport master (
    output penable, restart, out_req, out_count, pull_req, pull_block, pull_ifempty,
           autopull, pull_thresh, x_in, fifo_empty, fifo_data, osr_count,
    input  fifo_pop, osr_set, osr_din, osr_do_shift, osr_shift, stall, stall_cycles
  );

  modport slave (
    input  penable, restart, out_req, out_count, pull_req, pull_block, pull_ifempty,
           autopull, pull_thresh, x_in, fifo_empty, fifo_data, osr_count,
    output fifo_pop, osr_set, osr_din, osr_do_shift, osr_shift, stall, stall_cycles
  );
endinterface

// File: rtl/osr_pull_ctrl.sv
// OSR sequencing controller: chooses shift / FIFO load / X load each enabled cycle,
// drives the sequencer stall and tracks blocking waits with a saturating stall counter.
module osr_pull_ctrl (
  input  logic           clk,
  input  logic           reset,
  osr_pull_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, WAIT_PULL, WAIT_OUT} state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [5:0]  th;
  logic        used;
  logic        have_word;
  logic        pop, set, do_shift, stall;

  assign th        = (bus.pull_thresh == 5'd0) ? 6'd32 : {1'b0, bus.pull_thresh};
  assign used      = (bus.osr_count >= th);
  assign have_word = !bus.fifo_empty;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    set      = 1'b0;
    do_shift = 1'b0;
    stall    = 1'b0;

    if (bus.penable) begin
      case (state_q)
        RUN: begin
          if (bus.pull_req) begin
            if (bus.pull_ifempty && !used) begin
              stall = 1'b0;
            end else if (have_word) begin
              pop = 1'b1;
              set = 1'b1;
            end else if (bus.pull_block) begin
              stall   = 1'b1;
              state_d = WAIT_PULL;
            end else begin
              set = 1'b1;
            end
          end else if (bus.out_req) begin
            if (bus.autopull && used) begin
              // The OUT is re-presented next cycle against the refilled OSR.
              stall = 1'b1;
              if (have_word) begin
                pop = 1'b1;
                set = 1'b1;
              end else begin
                state_d = WAIT_OUT;
              end
            end else begin
              do_shift = 1'b1;
            end
          end else if (bus.autopull && used && have_word) begin
            pop = 1'b1;
            set = 1'b1;
          end
        end
        WAIT_PULL, WAIT_OUT: begin
          if (have_word) begin
            pop     = 1'b1;
            set     = 1'b1;
            stall   = (state_q == WAIT_OUT);
            state_d = RUN;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end

    // Restart only drops the OSR strobes; the stall still counts for this cycle.
    if (reset) begin
      state_d  = RUN;
      pop      = 1'b0;
      set      = 1'b0;
      do_shift = 1'b0;
      stall    = 1'b0;
    end else if (bus.restart) begin
      state_d  = RUN;
      pop      = 1'b0;
      set      = 1'b0;
      do_shift = 1'b0;
    end

    stall_cycles_d = stall_cycles_q;
    if (bus.penable && stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.fifo_pop     = pop;
  assign bus.osr_set      = set;
  assign bus.osr_din      = pop ? bus.fifo_data : bus.x_in;
  assign bus.osr_do_shift = do_shift;
  assign bus.osr_shift    = bus.out_count;
  assign bus.stall        = stall;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_osr_pull_ctrl.sv
// Self-checking bench for osr_pull_ctrl: directed vector table, multi-cycle sequences,
// and randomized cycles compared against a rule-level reference model.
module tb_osr_pull_ctrl;

  typedef struct packed {
    logic        penable;
    logic        restart;
    logic        out_req;
    logic [4:0]  out_count;
    logic        pull_req;
    logic        pull_block;
    logic        pull_ifempty;
    logic        autopull;
    logic [4:0]  pull_thresh;
    logic [31:0] x_in;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic [5:0]  osr_count;
  } in_t;

  typedef struct packed {
    logic        fifo_pop;
    logic        osr_set;
    logic [31:0] osr_din;
    logic        osr_do_shift;
    logic [4:0]  osr_shift;
    logic        stall;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  localparam int M_RUN = 0;
  localparam int M_WP  = 1;
  localparam int M_WO  = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[$];

  osr_pull_ctrl_if bus();

  osr_pull_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t idle_in();
    in_t t;
    t = '0;
    t.penable    = 1'b1;
    t.fifo_empty = 1'b1;
    return t;
  endfunction

  function automatic out_t mk_out(input logic pop, input logic set, input logic [31:0] din,
                                  input logic sh, input logic [4:0] n, input logic st);
    out_t o;
    o.fifo_pop     = pop;
    o.osr_set      = set;
    o.osr_din      = din;
    o.osr_do_shift = sh;
    o.osr_shift    = n;
    o.stall        = st;
    return o;
  endfunction

  // Rule-level reference: mode is 0 run, 1 waiting on PULL, 2 waiting on OUT.
  function automatic void ref_step(input in_t i, input int mode, input logic rst,
                                   output out_t o, output int next_mode);
    int  th;
    bit  used;
    bit  take;
    bit  load_x;
    bit  st;
    bit  sh;
    th        = (i.pull_thresh == 0) ? 32 : int'(i.pull_thresh);
    used      = int'(i.osr_count) >= th;
    take      = 0;
    load_x    = 0;
    st        = 0;
    sh        = 0;
    next_mode = mode;
    if (i.penable) begin
      if (mode != M_RUN) begin
        if (!i.fifo_empty) begin
          take      = 1;
          st        = (mode == M_WO);
          next_mode = M_RUN;
        end else begin
          st = 1;
        end
      end else if (i.pull_req) begin
        if (!(i.pull_ifempty && !used)) begin
          if (!i.fifo_empty) take = 1;
          else if (i.pull_block) begin st = 1; next_mode = M_WP; end
          else load_x = 1;
        end
      end else if (i.out_req) begin
        if (i.autopull && used) begin
          st = 1;
          if (!i.fifo_empty) take = 1;
          else next_mode = M_WO;
        end else begin
          sh = 1;
        end
      end else if (i.autopull && used && !i.fifo_empty) begin
        take = 1;
      end
    end
    if (rst) begin
      take = 0; load_x = 0; sh = 0; st = 0; next_mode = M_RUN;
    end else if (i.restart) begin
      take = 0; load_x = 0; sh = 0; next_mode = M_RUN;
    end
    o = mk_out(take, take | load_x, take ? i.fifo_data : i.x_in, sh, i.out_count, st);
  endfunction

  task automatic applyStimulus(input in_t v);
    bus.penable      = v.penable;
    bus.restart      = v.restart;
    bus.out_req      = v.out_req;
    bus.out_count    = v.out_count;
    bus.pull_req     = v.pull_req;
    bus.pull_block   = v.pull_block;
    bus.pull_ifempty = v.pull_ifempty;
    bus.autopull     = v.autopull;
    bus.pull_thresh  = v.pull_thresh;
    bus.x_in         = v.x_in;
    bus.fifo_empty   = v.fifo_empty;
    bus.fifo_data    = v.fifo_data;
    bus.osr_count    = v.osr_count;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t got;
    got = mk_out(bus.fifo_pop, bus.osr_set, bus.osr_din, bus.osr_do_shift, bus.osr_shift, bus.stall);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got pop=%b set=%b din=%h shift=%b n=%0d stall=%b, exp pop=%b set=%b din=%h shift=%b n=%0d stall=%b",
               name, got.fifo_pop, got.osr_set, got.osr_din, got.osr_do_shift, got.osr_shift, got.stall,
               exp.fifo_pop, exp.osr_set, exp.osr_din, exp.osr_do_shift, exp.osr_shift, exp.stall);
    end
  endtask

  task automatic checkCount(input string name, input int exp);
    total++;
    if (int'(bus.stall_cycles) != exp) begin
      bad++;
      $display("[TB] FAIL %s: stall_cycles got %0d exp %0d", name, bus.stall_cycles, exp);
    end
  endtask

  // Tasks start and end 1 time unit after a rising edge; checks land on the falling edge.
  task automatic do_reset();
    reset = 1'b1;
    applyStimulus(idle_in());
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic cyc(input string name, input out_t exp, input int exp_cnt);
    @(negedge clk);
    checkOutput(name, exp);
    if (exp_cnt >= 0) checkCount({name, "_cnt"}, exp_cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input in_t i, input out_t o);
    vec_t v;
    v.name = name;
    v.i    = i;
    v.o    = o;
    vecs.push_back(v);
  endtask

  initial begin
    in_t  t;
    out_t eo;
    int   mode;
    int   nm;
    int   cnt;
    logic rst;
    int   r;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    applyStimulus(idle_in());
    @(posedge clk);
    #1;
    do_reset();
    cyc("reset_idle", mk_out(0, 0, 32'h0, 0, 5'd0, 0), 0);

    t = idle_in(); add_vec("idle", t, mk_out(0, 0, 32'h0, 0, 5'd0, 0));
    t = idle_in(); t.out_req = 1; t.out_count = 8; t.x_in = 32'hDEADBEEF;
    add_vec("out_shift", t, mk_out(0, 0, 32'hDEADBEEF, 1, 5'd8, 0));
    t = idle_in(); t.pull_req = 1; t.x_in = 32'h0000A5A5;
    add_vec("pull_nb_x", t, mk_out(0, 1, 32'h0000A5A5, 0, 5'd0, 0));
    t = idle_in(); t.pull_req = 1; t.fifo_empty = 0; t.fifo_data = 32'h11223344; t.x_in = 32'h5;
    add_vec("pull_fifo", t, mk_out(1, 1, 32'h11223344, 0, 5'd0, 0));
    t = idle_in(); t.pull_req = 1; t.pull_ifempty = 1; t.osr_count = 4; t.pull_thresh = 16;
    t.fifo_empty = 0; t.fifo_data = 32'h9; t.x_in = 32'h7;
    add_vec("ifempty_skip", t, mk_out(0, 0, 32'h7, 0, 5'd0, 0));
    t.osr_count = 16; t.fifo_data = 32'h1;
    add_vec("ifempty_go", t, mk_out(1, 1, 32'h1, 0, 5'd0, 0));
    t = idle_in(); t.pull_req = 1; t.pull_block = 1;
    add_vec("pull_block", t, mk_out(0, 0, 32'h0, 0, 5'd0, 1));
    t = idle_in(); t.autopull = 1; t.pull_thresh = 8; t.osr_count = 8; t.out_req = 1; t.out_count = 3;
    t.fifo_empty = 0; t.fifo_data = 32'hCAFEF00D;
    add_vec("ap_out_refill", t, mk_out(1, 1, 32'hCAFEF00D, 0, 5'd3, 1));
    t = idle_in(); t.autopull = 1; t.osr_count = 32; t.fifo_empty = 0; t.fifo_data = 32'h55;
    add_vec("ap_background", t, mk_out(1, 1, 32'h55, 0, 5'd0, 0));
    t = idle_in(); t.autopull = 1; t.osr_count = 31; t.out_req = 1; t.out_count = 4;
    t.fifo_empty = 0; t.fifo_data = 32'h66;
    add_vec("ap_th32_edge", t, mk_out(0, 0, 32'h0, 1, 5'd4, 0));
    t = idle_in(); t.pull_req = 1; t.out_req = 1; t.out_count = 2; t.x_in = 32'h3;
    add_vec("both_req", t, mk_out(0, 1, 32'h3, 0, 5'd2, 0));
    t = idle_in(); t.penable = 0; t.pull_req = 1; t.fifo_empty = 0; t.fifo_data = 32'h77;
    add_vec("penable_off", t, mk_out(0, 0, 32'h0, 0, 5'd0, 0));
    t = idle_in(); t.restart = 1; t.pull_req = 1; t.fifo_empty = 0; t.fifo_data = 32'h88; t.x_in = 32'h9;
    add_vec("restart_run", t, mk_out(0, 0, 32'h9, 0, 5'd0, 0));
    t = idle_in(); t.autopull = 1; t.osr_count = 32; t.out_req = 1;
    add_vec("ap_out_empty", t, mk_out(0, 0, 32'h0, 0, 5'd0, 1));

    foreach (vecs[k]) begin
      do_reset();
      applyStimulus(vecs[k].i);
      cyc(vecs[k].name, vecs[k].o, -1);
    end

    // Blocking PULL waits three cycles, then completes on the FIFO arrival.
    do_reset();
    t = idle_in(); t.pull_req = 1; t.pull_block = 1;
    applyStimulus(t);
    for (int c = 0; c < 3; c++) cyc("bpull_wait", mk_out(0, 0, 32'h0, 0, 5'd0, 1), c);
    t.fifo_empty = 0; t.fifo_data = 32'h12345678;
    applyStimulus(t);
    cyc("bpull_done", mk_out(1, 1, 32'h12345678, 0, 5'd0, 0), 3);
    t = idle_in(); t.fifo_empty = 0; t.fifo_data = 32'hABCD;
    applyStimulus(t);
    cyc("bpull_back_run", mk_out(0, 0, 32'h0, 0, 5'd0, 0), 3);

    // Autopull refill costs one stall cycle, then the OUT shifts.
    do_reset();
    t = idle_in(); t.autopull = 1; t.pull_thresh = 8; t.osr_count = 8; t.out_req = 1; t.out_count = 8;
    t.fifo_empty = 0; t.fifo_data = 32'hCAFEF00D;
    applyStimulus(t);
    cyc("ap_refill_c1", mk_out(1, 1, 32'hCAFEF00D, 0, 5'd8, 1), 0);
    t.osr_count = 0;
    applyStimulus(t);
    cyc("ap_refill_c2", mk_out(0, 0, 32'h0, 1, 5'd8, 0), 1);

    // WAIT_OUT completes with a reissue stall.
    do_reset();
    t = idle_in(); t.autopull = 1; t.osr_count = 32; t.out_req = 1; t.out_count = 5;
    applyStimulus(t);
    cyc("wo_enter", mk_out(0, 0, 32'h0, 0, 5'd5, 1), 0);
    cyc("wo_wait", mk_out(0, 0, 32'h0, 0, 5'd5, 1), 1);
    t.fifo_empty = 0; t.fifo_data = 32'hBEEF0001;
    applyStimulus(t);
    cyc("wo_arrive", mk_out(1, 1, 32'hBEEF0001, 0, 5'd5, 1), 2);
    t.osr_count = 0;
    applyStimulus(t);
    cyc("wo_reissue", mk_out(0, 0, 32'h0, 1, 5'd5, 0), 3);

    // Reset on the second stall cycle of WAIT_OUT.
    do_reset();
    t = idle_in(); t.autopull = 1; t.osr_count = 32; t.out_req = 1;
    applyStimulus(t);
    cyc("wo_rst_enter", mk_out(0, 0, 32'h0, 0, 5'd0, 1), 0);
    reset = 1'b1;
    t.fifo_empty = 0; t.fifo_data = 32'h44;
    applyStimulus(t);
    cyc("wo_rst_cycle", mk_out(0, 0, 32'h0, 0, 5'd0, 0), 1);
    reset = 1'b0;
    t = idle_in(); t.fifo_empty = 0; t.fifo_data = 32'h44;
    applyStimulus(t);
    cyc("wo_rst_after", mk_out(0, 0, 32'h0, 0, 5'd0, 0), 0);

    // Restart on the second stall cycle keeps the counter.
    do_reset();
    t = idle_in(); t.autopull = 1; t.osr_count = 32; t.out_req = 1;
    applyStimulus(t);
    cyc("wo_rs_enter", mk_out(0, 0, 32'h0, 0, 5'd0, 1), 0);
    t.restart = 1; t.fifo_empty = 0; t.fifo_data = 32'h45;
    applyStimulus(t);
    cyc("wo_rs_cycle", mk_out(0, 0, 32'h0, 0, 5'd0, 1), 1);
    t = idle_in(); t.fifo_empty = 0; t.fifo_data = 32'h45;
    applyStimulus(t);
    cyc("wo_rs_after", mk_out(0, 0, 32'h0, 0, 5'd0, 0), 2);

    // Randomized cycles against the reference model.
    do_reset();
    mode = M_RUN;
    cnt  = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      t = '0;
      t.penable      = ($urandom_range(0, 9) != 0);
      t.restart      = ($urandom_range(0, 29) == 0);
      r = $urandom_range(0, 9);
      t.out_req      = (r < 4) || (r == 7);
      t.pull_req     = (r >= 4) && (r <= 7);
      t.out_count    = 5'($urandom);
      t.pull_block   = 1'($urandom);
      t.pull_ifempty = 1'($urandom);
      t.autopull     = 1'($urandom);
      t.pull_thresh  = 5'($urandom);
      t.x_in         = $urandom;
      t.fifo_empty   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
      t.fifo_data    = $urandom;
      t.osr_count    = 6'($urandom_range(0, 32));
      reset = rst;
      applyStimulus(t);
      ref_step(t, mode, rst, eo, nm);
      @(negedge clk);
      checkOutput("rand_out", eo);
      checkCount("rand_cnt", cnt);
      mode = nm;
      if (rst) cnt = 0;
      else if (eo.stall && cnt < 65535) cnt++;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/osr_pull_ctrl.md
# osr_pull_ctrl

Sequencing controller for the output shift register of one state machine. It decides each enabled cycle whether the OSR shifts (OUT), loads from the TX FIFO (PULL, or autopull), loads from X (non-blocking PULL on an empty FIFO), or does nothing. It drives the sequencer stall, and tracks blocking waits in a small state machine with a saturating stall counter. It sits between the instruction decoder, the TX FIFO read port and the OSR, and is the only driver of the OSR's `set`, `do_shift`, `din` and `shift` inputs.

## Interface
- Parameters: none (data width fixed at 32, shift counts at 5 bits, 0 = 32).
- `clk  in  1` system clock
- `reset  in  1` synchronous, active-high; clears state and counter
- `penable  in  1` state-machine clock enable; when low, no strobes, no state change
- `restart  in  1` synchronous SM restart; forces state to RUN, does not clear counter
- `out_req  in  1` decoded OUT instruction this cycle
- `out_count  in  5` OUT bit count (0 = 32)
- `pull_req  in  1` decoded PULL instruction this cycle
- `pull_block  in  1` PULL block bit
- `pull_ifempty  in  1` PULL IfEmpty bit
- `autopull  in  1` SHIFTCTRL autopull enable
- `pull_thresh  in  5` autopull threshold (0 = 32)
- `x_in  in  32` scratch X value
- `fifo_empty  in  1` TX FIFO empty
- `fifo_data  in  32` TX FIFO head word
- `osr_count  in  6` OSR shift count (0..32; 32 = empty)
- `fifo_pop  out  1` pop TX FIFO head (combinational)
- `osr_set  out  1` load OSR with `osr_din`
- `osr_din  out  32` `fifo_data` when popping, else `x_in`
- `osr_do_shift  out  1` shift OSR by `osr_shift`
- `osr_shift  out  5` equals `out_count`
- `stall  out  1` hold PC and re-present the instruction next cycle
- `stall_cycles  out  16` saturating count of stalled enabled cycles

## Operation
- Derived signals: `th` = 32 if `pull_thresh` is 0, else `pull_thresh`. `used` = (`osr_count` >= `th`).
- States: RUN, WAIT_PULL, WAIT_OUT. All outputs are combinational from state and inputs. Only the state and `stall_cycles` are registered.
- RUN, `pull_req`:
  - `pull_ifempty` and not `used`: no-op, `stall` = 0.
  - Else FIFO not empty: `fifo_pop` = `osr_set` = 1, `osr_din` = `fifo_data`, `stall` = 0.
  - Else `pull_block`: `stall` = 1, next state WAIT_PULL.
  - Else: `osr_set` = 1, `osr_din` = `x_in`, no pop, `stall` = 0.
- RUN, `out_req`:
  - `autopull` and `used` and FIFO not empty: pop and set with `fifo_data`, `stall` = 1. The OUT is re-presented next cycle against the fresh OSR.
  - `autopull` and `used` and FIFO empty: `stall` = 1, next state WAIT_OUT.
  - Otherwise: `osr_do_shift` = 1, `osr_shift` = `out_count`, `stall` = 0.
- RUN, no request: background autopull. If `autopull` and `used` and FIFO not empty, pop and set. `stall` = 0.
- WAIT_PULL / WAIT_OUT: `stall` = 1 while the FIFO is empty.
  - When the FIFO goes non-empty: pop and set with `fifo_data`, then go to RUN.
  - WAIT_PULL: `stall` = 0 in that cycle (PULL completes).
  - WAIT_OUT: `stall` = 1 in that cycle (OUT reissues).
- `out_req` and `pull_req` together is illegal. PULL takes priority and OUT is ignored.
- `osr_set` and `osr_do_shift` are never both 1.
- `stall_cycles` increments on every enabled cycle with `stall` = 1 and saturates at 0xFFFF.

## Timing
- Reset values: state RUN, `stall_cycles` 0. With no request, all strobes and `stall` are 0.
- Strobes are same-cycle: the OSR registers the load or shift at the next edge. FIFO pop latency is 0 (head word valid while `fifo_empty` = 0).
- `penable` = 0: all strobes 0, `stall` 0, state and counter hold.
- `restart` (with `penable` either value): next state RUN, no pop and no set that cycle. Takes precedence over a FIFO arrival.
- `reset` overrides `restart` and `penable`. Reset mid-WAIT gives RUN next cycle, no pop issued.
- Autopull refill on OUT costs exactly 1 stall cycle when the FIFO is non-empty.
- `osr_count` is 32 after OSR reset/restart, so the first OUT with autopull always refills first.

## Test plan
- Autopull off, OSR holds 0xDEADBEEF with count 0, `out_req`, `out_count` 8 → `osr_do_shift` 1, `osr_shift` 8, `stall` 0, no pop.
- Blocking PULL, FIFO empty for 3 cycles, then head 0x12345678 → `stall` 1 for 3 cycles in WAIT_PULL. In the 4th cycle `fifo_pop` = `osr_set` = 1, `osr_din` 0x12345678, `stall` 0. Next state RUN, `stall_cycles` 3.
- Non-blocking PULL, FIFO empty, `x_in` 0x0000A5A5 → `osr_set` 1, `osr_din` 0x0000A5A5, `fifo_pop` 0, `stall` 0.
- Autopull, `pull_thresh` 8, `osr_count` 8, `out_req`, FIFO head 0xCAFEF00D:
  - Cycle 1: pop+set, `stall` 1.
  - Cycle 2 (`osr_count` 0): `osr_do_shift` 1, `stall` 0.
- PULL IfEmpty with `osr_count` 4 and `pull_thresh` 16 → no strobes, `stall` 0. With `osr_count` 16 and FIFO head 0x1 → pop+set.
- Autopull, FIFO empty, OUT gives WAIT_OUT. Assert `reset` on the 2nd stall cycle → state RUN, `stall_cycles` 0, no pop. Repeat with `restart` → RUN, counter retained at 2.
